// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - width helpers and FWFT output-stage state for sync_fifo_flags
package sync_fifo_pkg;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_VALID = 1'b1
    } out_state_t;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

    // One extra bit so the pointers can tell a full FIFO from an empty one.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// rtl/fifo_sdp_ram.sv - simple dual-port RAM, one write port and one registered read port
module fifo_sdp_ram #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Only the read register is reset; the array keeps whatever it held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - single-clock FIFO with count, threshold flags, sticky errors, flush
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; default is 1-cycle read latency.
module sync_fifo_flags
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    output logic                   full,
    output logic                   almost_full,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   rd_valid,
    output logic                   empty,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int ADDR_W = addr_w(DEPTH);
    localparam int CNT_W  = cnt_w(DEPTH);

    logic [CNT_W-1:0] wr_ptr;
    logic [CNT_W-1:0] rd_ptr;
    logic [CNT_W-1:0] ram_count;
    logic             ram_empty;
    logic             wr_accept;
    logic             rd_advance;
    logic             underflow_set;

    assign ram_count = wr_ptr - rd_ptr;
    assign ram_empty = (wr_ptr == rd_ptr);
    assign wr_accept = wr_en && !full && !flush;

`ifdef SYNC_FIFO_FWFT_EN
    out_state_t out_state;
    out_state_t out_state_next;
    logic       pop;

    assign pop        = rd_en && (out_state == OUT_VALID);
    assign rd_advance = !ram_empty && !flush && ((out_state == OUT_EMPTY) || pop);
    assign rd_valid   = (out_state == OUT_VALID);
    assign empty      = !rd_valid;
    assign count      = ram_count + CNT_W'(rd_valid);
    assign full       = (32'(count) == DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_state <= OUT_EMPTY;
        end else begin
            out_state <= out_state_next;
        end
    end

    always_comb begin
        out_state_next = out_state;
        if (flush) begin
            out_state_next = OUT_EMPTY;
        end else if (rd_advance) begin
            out_state_next = OUT_VALID;
        end else if (pop) begin
            out_state_next = OUT_EMPTY;
        end
    end
`else
    logic rd_valid_q;

    assign empty      = ram_empty;
    assign full       = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                        (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign count      = ram_count;
    assign rd_advance = rd_en && !ram_empty && !flush;
    assign rd_valid   = rd_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_advance;
        end
    end
`endif

    assign almost_full  = (32'(count) >= AF_THRESH);
    assign almost_empty = (32'(count) <= AE_THRESH);

    // A read colliding with a write into a completely empty FIFO loses nothing, so it is not an error.
    assign underflow_set = rd_en && empty && !(wr_en && (count == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_advance) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (underflow_set) begin
                underflow <= 1'b1;
            end
        end
    end

    fifo_sdp_ram #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_accept),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (wr_data),
        .re    (rd_advance),
        .raddr (rd_ptr[ADDR_W-1:0]),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb/tb_sync_fifo_flags.sv - directed self-checking bench for sync_fifo_flags (WIDTH=8, DEPTH=8)
module tb_sync_fifo_flags;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             wr_en = 1'b0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             rd_en = 1'b0;
    logic             full;
    logic             almost_full;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             empty;
    logic             almost_empty;
    logic [3:0]       count;
    logic             overflow;
    logic             underflow;

    int checks = 0;
    int failures = 0;

    sync_fifo_flags #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AF_THRESH (6),
        .AE_THRESH (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .full         (full),
        .almost_full  (almost_full),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .empty        (empty),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #23;
        chk("reset_count", 32'(count), 0);
        chk("reset_empty", 32'(empty), 1);
        chk("reset_full", 32'(full), 0);
        chk("reset_ae", 32'(almost_empty), 1);
        chk("reset_af", 32'(almost_full), 0);
        chk("reset_rd_valid", 32'(rd_valid), 0);
        chk("reset_rd_data", 32'(rd_data), 0);
        chk("reset_errors", {30'b0, overflow, underflow}, 0);
        rst_n = 1'b1;
        tick();

`ifdef SYNC_FIFO_FWFT_EN
        wr_en = 1'b1; wr_data = 8'hA5;
        tick();
        wr_en = 1'b0;
        chk("fwft_e0_rd_valid", 32'(rd_valid), 0);
        chk("fwft_e0_count", 32'(count), 1);
        tick();
        chk("fwft_e1_rd_valid", 32'(rd_valid), 1);
        chk("fwft_e1_rd_data", 32'(rd_data), 32'hA5);
        tick();
        chk("fwft_hold_rd_valid", 32'(rd_valid), 1);
        chk("fwft_hold_rd_data", 32'(rd_data), 32'hA5);
        rd_en = 1'b1;
        tick();
        chk("fwft_pop_empty", 32'(empty), 1);
        chk("fwft_pop_count", 32'(count), 0);
        tick();
        rd_en = 1'b0;
        chk("fwft_underflow", 32'(underflow), 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
`endif

        for (int i = 1; i <= 8; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            tick();
            chk($sformatf("fill_count_%0d", i), 32'(count), i);
            chk($sformatf("fill_af_%0d", i), 32'(almost_full), (i >= 6) ? 1 : 0);
            chk($sformatf("fill_ae_%0d", i), 32'(almost_empty), (i <= 2) ? 1 : 0);
            chk($sformatf("fill_full_%0d", i), 32'(full), (i == 8) ? 1 : 0);
        end
        wr_data = 8'h99;
        tick();
        wr_en = 1'b0;
        chk("ovf_count", 32'(count), 8);
        chk("ovf_flag", 32'(overflow), 1);

`ifdef SYNC_FIFO_FWFT_EN
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("fwft_drain_valid_%0d", i), 32'(rd_valid), 1);
            chk($sformatf("fwft_drain_data_%0d", i), 32'(rd_data), i);
            rd_en = 1'b1;
            tick();
            chk($sformatf("fwft_drain_count_%0d", i), 32'(count), 8 - i);
        end
        rd_en = 1'b0;
        chk("fwft_drain_empty", 32'(empty), 1);
        chk("fwft_ovf_sticky", 32'(overflow), 1);
`else
        for (int i = 1; i <= 8; i++) begin
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
            chk($sformatf("drain_valid_%0d", i), 32'(rd_valid), 1);
            chk($sformatf("drain_data_%0d", i), 32'(rd_data), i);
            chk($sformatf("drain_count_%0d", i), 32'(count), 8 - i);
            tick();
            chk($sformatf("drain_pulse_%0d", i), 32'(rd_valid), 0);
            chk($sformatf("drain_hold_%0d", i), 32'(rd_data), i);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("udf_flag", 32'(underflow), 1);
        chk("udf_rd_valid", 32'(rd_valid), 0);
        chk("udf_rd_data", 32'(rd_data), 8);
        chk("ovf_sticky", 32'(overflow), 1);

        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_clear_errors", {30'b0, overflow, underflow}, 0);

        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h10 + i);
            tick();
        end
        for (int k = 0; k < 20; k++) begin
            wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'(8'h13 + k);
            tick();
            chk($sformatf("wrap_count_%0d", k), 32'(count), 3);
            chk($sformatf("wrap_data_%0d", k), 32'(rd_data), 32'h10 + k);
        end
        wr_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rd_en = 1'b1;
            tick();
            chk($sformatf("wrap_tail_%0d", k), 32'(rd_data), 32'h24 + k);
        end
        rd_en = 1'b0;
        chk("wrap_empty", 32'(empty), 1);

        wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h5A;
        tick();
        rd_en = 1'b0;
        chk("empty_wr_rd_count", 32'(count), 1);
        chk("empty_wr_rd_udf", 32'(underflow), 0);
        chk("empty_wr_rd_valid", 32'(rd_valid), 0);
        for (int i = 1; i <= 7; i++) begin
            wr_data = 8'(8'h60 + i);
            tick();
        end
        chk("refill_full", 32'(full), 1);
        rd_en = 1'b1; wr_data = 8'hEE;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("full_wr_rd_count", 32'(count), 7);
        chk("full_wr_rd_data", 32'(rd_data), 32'h5A);
        chk("full_wr_rd_ovf", 32'(overflow), 1);
        for (int i = 1; i <= 7; i++) begin
            rd_en = 1'b1;
            tick();
            chk($sformatf("full_drain_%0d", i), 32'(rd_data), 32'h60 + i);
        end
        rd_en = 1'b0;
        chk("full_drain_empty", 32'(empty), 1);

        for (int i = 1; i <= 5; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h70 + i);
            tick();
        end
        chk("preflush_count", 32'(count), 5);
        chk("preflush_ovf", 32'(overflow), 1);
        flush = 1'b1; rd_en = 1'b1; wr_data = 8'hCC;
        tick();
        flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        chk("flush_count", 32'(count), 0);
        chk("flush_empty", 32'(empty), 1);
        chk("flush_ovf", 32'(overflow), 0);
        chk("flush_udf", 32'(underflow), 0);
        chk("flush_rd_valid", 32'(rd_valid), 0);
        chk("flush_rd_data_hold", 32'(rd_data), 32'h67);
`endif

        wr_en = 1'b1; wr_data = 8'h33;
        tick();
        tick();
        wr_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_count", 32'(count), 0);
        chk("async_rst_empty", 32'(empty), 1);
        chk("async_rst_rd_data", 32'(rd_data), 0);
        #10;
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
